// File: rtl/uart_rx_os.sv
// UART receive engine: oversampled serial input, 3-sample majority per bit, 5..8 data bits, optional parity.
// Latency: rx_valid rises 1 clk after the stop-bit vote tick (MID+1 ticks into the stop bit).
// Backpressure: a finished word is held until rx_valid&&rx_ready; a frame completing while held is dropped with overrun_err.
module uart_rx_os #(
   parameter int OSR         = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_en,
   input  logic       rxd,
   input  logic [1:0] wls,
   input  logic       pen,
   input  logic       eps,
   input  logic       sp,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       parity_err,
   output logic       framing_err,
   output logic       break_det,
   output logic       overrun_err,
   output logic       busy
);

   localparam int CW = $clog2(OSR);
   localparam logic [CW-1:0] C_MIDM1 = CW'(OSR/2 - 1);
   localparam logic [CW-1:0] C_MID   = CW'(OSR/2);
   localparam logic [CW-1:0] C_MIDP1 = CW'(OSR/2 + 1);
   localparam logic [CW-1:0] C_LAST  = CW'(OSR - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   logic                   prev_s;
   logic [CW-1:0]          cnt, cnt_n;
   logic [2:0]             idx, idx_n;
   logic [7:0]             shift, shift_n;
   logic                   smp0, smp0_n, smp1, smp1_n;
   logic                   any_one, any_one_n;
   logic                   par_bit, par_bit_n;
   logic [1:0]             wls_q, wls_n;
   logic                   pen_q, pen_n, eps_q, eps_n, sp_q, sp_n;
   logic                   vote, vote_tick;
   logic [2:0]             last_idx;
   logic                   done, stop_vote;
   logic                   exp_par, par_err_c, brk_c;

   assign rxd_s     = sync_q[SYNC_STAGES-1];
   assign vote      = (smp0 & smp1) | (smp0 & rxd_s) | (smp1 & rxd_s);
   assign vote_tick = sample_en && (cnt == C_MIDP1);
   assign last_idx  = 3'd4 + {1'b0, wls_q};
   assign busy      = (state != S_IDLE);

   // Unused MSBs of shift stay zero, so the reduction covers exactly nbits.
   assign exp_par   = sp_q ? ~eps_q : (eps_q ? ^shift : ~^shift);
   assign par_err_c = pen_q && (par_bit != exp_par);
   assign brk_c     = !any_one && !stop_vote;

   // Bring the asynchronous line into the clk domain; idle level is high.
   always_ff @(posedge clk) begin
      if (reset) sync_q <= '1;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
   end

   // Frame sequencing: every step is gated by the oversample tick.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      shift_n   = shift;
      smp0_n    = smp0;
      smp1_n    = smp1;
      any_one_n = any_one;
      par_bit_n = par_bit;
      wls_n     = wls_q;
      pen_n     = pen_q;
      eps_n     = eps_q;
      sp_n      = sp_q;
      done      = 1'b0;
      stop_vote = 1'b1;
      if (sample_en) begin
         if (cnt == C_MIDM1) smp0_n = rxd_s;
         if (cnt == C_MID)   smp1_n = rxd_s;
         cnt_n = (cnt == C_LAST) ? '0 : cnt + 1'b1;
         case (state)
            S_IDLE: begin
               cnt_n = '0;
               // Only a true high->low transition starts a frame, so a stuck-low line never re-triggers.
               if (prev_s && !rxd_s) begin
                  state_n   = S_START;
                  idx_n     = '0;
                  shift_n   = '0;
                  any_one_n = 1'b0;
                  par_bit_n = 1'b0;
                  wls_n     = wls;
                  pen_n     = pen;
                  eps_n     = eps;
                  sp_n      = sp;
               end
            end
            S_START: begin
               if (vote_tick && vote) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end else if (cnt == C_LAST) begin
                  state_n = S_DATA;
                  idx_n   = '0;
               end
            end
            S_DATA: begin
               if (vote_tick) begin
                  shift_n[idx] = vote;
                  if (vote) any_one_n = 1'b1;
               end
               if (cnt == C_LAST) begin
                  if (idx == last_idx) state_n = pen_q ? S_PARITY : S_STOP;
                  else                 idx_n   = idx + 3'd1;
               end
            end
            S_PARITY: begin
               if (vote_tick) begin
                  par_bit_n = vote;
                  if (vote) any_one_n = 1'b1;
               end
               if (cnt == C_LAST) state_n = S_STOP;
            end
            S_STOP: begin
               // Finish at mid stop bit, leaving half a bit of slack before the next start edge.
               if (vote_tick) begin
                  done      = 1'b1;
                  stop_vote = vote;
                  state_n   = S_IDLE;
                  cnt_n     = '0;
               end
            end
            default: begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // Frame state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         idx     <= '0;
         shift   <= '0;
         smp0    <= 1'b1;
         smp1    <= 1'b1;
         any_one <= 1'b0;
         par_bit <= 1'b0;
         prev_s  <= 1'b1;
         wls_q   <= '0;
         pen_q   <= 1'b0;
         eps_q   <= 1'b0;
         sp_q    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shift   <= shift_n;
         smp0    <= smp0_n;
         smp1    <= smp1_n;
         any_one <= any_one_n;
         par_bit <= par_bit_n;
         wls_q   <= wls_n;
         pen_q   <= pen_n;
         eps_q   <= eps_n;
         sp_q    <= sp_n;
         if (sample_en) prev_s <= rxd_s;
      end
   end

   // Output holding register: load on completion if free or being drained, otherwise flag overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         break_det   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (done) begin
            if (!rx_valid || rx_ready) begin
               rx_data     <= shift;
               parity_err  <= par_err_c;
               framing_err <= !stop_vote;
               break_det   <= brk_c;
               rx_valid    <= 1'b1;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised UART receive engine. It oversamples the serial line at a configurable ratio and decides each bit by 3-sample majority vote. It supports 5–8 data bits with odd, even or stick parity, and detects parity, framing, break and overrun conditions. It sits between the baud generator (which supplies an oversample tick) and the receive FIFO/host register, and hands off each frame through a valid/ready handshake.

## Interface
- OSR, 16: oversample ticks per bit; even, 8..32; counter width $clog2(OSR)
- SYNC_STAGES, 2: input synchroniser depth, ≥2
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- sample_en  in  1  oversample tick, one clk wide, OSR per bit period
- rxd  in  1  asynchronous serial input, idle high
- wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits
- pen  in  1  parity enable
- eps  in  1  even parity select (1=even, 0=odd)
- sp  in  1  stick parity; with pen=1, parity bit must equal ~eps
- rx_data  out  8  received word, LSB-aligned, unused MSBs zero
- rx_valid  out  1  rx_data and error flags valid; held until accepted
- rx_ready  in  1  consumer accepts when rx_valid&&rx_ready
- parity_err  out  1  parity mismatch for the presented word
- framing_err  out  1  stop bit sampled low for the presented word
- break_det  out  1  data, parity and stop all sampled 0 for the presented word
- overrun_err  out  1  one-clk pulse: a frame completed while the previous one was held
- busy  out  1  high in any state other than IDLE

## Operation
- rxd passes through SYNC_STAGES flops (rxd_s). All further logic advances only on cycles with sample_en=1.
- States: IDLE, START, DATA, PARITY, STOP. cnt counts 0..OSR-1 within a bit. MID=OSR/2.
- Vote: rxd_s is captured at cnt=MID-1, MID, MID+1. The bit value is the majority of the three and is resolved on the tick with cnt=MID+1.
- IDLE: on a tick where the previous-tick rxd_s=1 and the current rxd_s=0, go to START with cnt=0. A line held low never re-triggers.
- START: if vote=1, treat as a false start and return to IDLE, setting no flag. Otherwise, at cnt=OSR-1 go to DATA with idx=0.
- DATA: store vote into shift[idx], LSB first. At cnt=OSR-1: if idx=nbits-1 go to PARITY (pen=1) or STOP (pen=0); otherwise idx+1.
- PARITY: expected bit is ^data when eps=1 (even), ~^data when eps=0, and ~eps when sp=1. Parity is evaluated over nbits only. At cnt=OSR-1 go to STOP.
- STOP: on the vote tick, complete the frame and go straight to IDLE (half-bit tolerance for the next start). Only the first stop bit is checked.
- Completion, case 1 (rx_valid=0, or rx_ready=1 in the same clk): load rx_data, parity_err, framing_err (stop vote=0) and break_det (all votes 0), and set rx_valid=1.
- Completion, case 2 (rx_valid=1 and rx_ready=0): drop the new frame, keep the held word, pulse overrun_err.
- Handshake: rx_valid clears on the clk after rx_valid&&rx_ready unless a completion loads in that same clk; in that case rx_valid stays 1 with the new data. The flags change only on load.
- wls, pen, eps and sp are sampled on the IDLE→START transition and are stable for the whole frame.

## Timing
- Reset values: rx_data=0, rx_valid=0, all error flags=0, overrun_err=0, busy=0, state=IDLE, cnt=0, idx=0, and the sync flops plus the previous-sample register are set to 1.
- Start-edge latency: SYNC_STAGES clk, then the next sample_en.
- rx_valid rises 1 clk after the stop-bit vote tick, which is MID+1 ticks into the stop bit.
- busy falls in the same clk that rx_valid rises.
- Reset mid-frame: next clk returns to IDLE, discards the partial frame, clears rx_valid and the flags. A start requires a fresh high→low edge.
- sample_en=0: all counters and state hold.
- Break with the line held low: the frame completes with break_det=1 and framing_err=1. No new start occurs until the line returns high and falls again.

## Test plan
- OSR=16, wls=11, pen=0, send 0xA5 → rx_data=0xA5, rx_valid=1, no flags; held until rx_ready; cleared 1 clk after accept.
- wls=00, pen=1, eps=1, send 0x13 with parity bit 0 → rx_data=0x13, parity_err=1. Repeat with parity bit 1 → parity_err=0.
- sp=1, eps=0, parity bit 1 → no error; parity bit 0 → parity_err=1.
- Line low for one full frame + 1 bit → rx_data=0x00, break_det=1, framing_err=1. No second frame until the line goes high.
- 2-tick low glitch in idle → false start, busy returns to 0, rx_valid stays 0. Single-tick glitch at MID inside a data bit → majority keeps the correct bit.
- Two frames with rx_ready=0 → first word held, overrun_err pulses once. Repeat with rx_ready asserted at the completion clk → second word loads and rx_valid stays 1.
